// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, PC source
// codes, parameter defaults and the PC source selection helper.
package instr_fetch_unit_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    typedef logic [1:0] pc_sel_t;

    localparam pc_sel_t PC_SEL_INC    = 2'b00;
    localparam pc_sel_t PC_SEL_BRANCH = 2'b01;
    localparam pc_sel_t PC_SEL_REG    = 2'b10;
    localparam pc_sel_t PC_SEL_HOLD   = 2'b11;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int          DEF_TIMEOUT  = 15;

    // Branch targets are relative to the instruction in IR, not the fetch PC.
    function automatic logic [31:0] pc_next(input pc_sel_t     sel,
                                            input logic [31:0] pc,
                                            input logic [31:0] ir_pc,
                                            input logic [31:0] k,
                                            input logic [31:0] reg_in);
        logic [31:0] nxt;
        case (sel)
            PC_SEL_INC:    nxt = pc + 32'd4;
            PC_SEL_BRANCH: nxt = ir_pc + (k << 2);
            PC_SEL_REG:    nxt = {reg_in[31:2], 2'b00};
            default:       nxt = pc;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read port: request/address out, ready/data back.
interface instr_fetch_unit_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ready, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ready, output mem_rdata);
endinterface

// File: rtl/fetch_timeout_counter.sv
// Counts stalled WAIT cycles; tc flags the last cycle allowed before a fault.
module fetch_timeout_counter #(
    parameter int TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset || clear)
            cnt <= '0;
        else if (enable && !tc)
            cnt <= cnt + 1'b1;
    end

    // cnt holds the number of stalled cycles already seen in this WAIT.
    assign tc = (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: IDLE/WAIT/FAULT fetch FSM, PC update mux and IR latch.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter int          TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                fetch_en,
    input  logic                pc_load,
    input  pc_sel_t             pc_sel,
    input  logic [31:0]         k,
    input  logic [31:0]         reg_in,
    instr_fetch_unit_if.master  mem,
    output logic [31:0]         IR,
    output logic                ir_valid,
    output logic [31:0]         PC,
    output logic [31:0]         ir_pc,
    output logic                busy,
    output logic                fault
);
    localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

    logic [1:0] state, state_nxt;
    logic       wait_clr, wait_en, wait_tc;

    assign wait_clr = (state != ST_WAIT);
    assign wait_en  = (state == ST_WAIT) && !mem.mem_ready;

    fetch_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (wait_clr),
        .enable (wait_en),
        .tc     (wait_tc)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (fetch_en) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (mem.mem_ready)  state_nxt = ST_IDLE;
                else if (wait_tc)   state_nxt = ST_FAULT;
            end
            ST_FAULT: state_nxt = ST_FAULT;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // A PC load and a fetch on the same IDLE edge fetch from the loaded PC,
    // since WAIT drives mem_addr straight from the updated register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            PC       <= RESET_PC_AL;
            IR       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            ir_valid <= 1'b0;
            if (state == ST_IDLE && pc_load)
                PC <= pc_next(pc_sel, PC, ir_pc, k, reg_in);
            if (state == ST_WAIT && mem.mem_ready) begin
                IR       <= mem.mem_rdata;
                ir_pc    <= PC;
                PC       <= PC + 32'd4;
                ir_valid <= 1'b1;
            end
        end
    end

    assign mem.mem_req  = (state == ST_WAIT);
    assign mem.mem_addr = PC;
    assign busy         = (state == ST_WAIT);
    assign fault        = (state == ST_FAULT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, timeout
// sequence and randomized traffic against a behavioural fetch model.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          TMO    = 15;

    logic        clock = 1'b0;
    logic        reset, fetch_en, pc_load;
    logic [1:0]  pc_sel;
    logic [31:0] k, reg_in;
    logic [31:0] IR, PC, ir_pc;
    logic        ir_valid, busy, fault;

    int vectors = 0;
    int miscompares = 0;

    instr_fetch_unit_if mem_bus();

    instr_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
        .clock    (clock),
        .reset    (reset),
        .fetch_en (fetch_en),
        .pc_load  (pc_load),
        .pc_sel   (pc_sel),
        .k        (k),
        .reg_in   (reg_in),
        .mem      (mem_bus),
        .IR       (IR),
        .ir_valid (ir_valid),
        .PC       (PC),
        .ir_pc    (ir_pc),
        .busy     (busy),
        .fault    (fault)
    );

    always #5 clock = ~clock;

    // Behavioural model: a fetch is outstanding, the unit is dead, or neither.
    bit          m_fetching, m_dead, m_valid;
    int          m_stalls;
    logic [31:0] m_pc, m_ir, m_irpc;

    task automatic model_edge();
        m_valid = 1'b0;
        if (reset) begin
            m_fetching = 0; m_dead = 0; m_stalls = 0;
            m_pc = RST_PC & ~32'd3; m_ir = 0; m_irpc = 0;
        end else if (m_dead) begin
            // everything ignored until reset
        end else if (m_fetching) begin
            if (mem_bus.mem_ready) begin
                m_ir = mem_bus.mem_rdata; m_irpc = m_pc; m_pc = m_pc + 4;
                m_valid = 1'b1; m_fetching = 0;
            end else begin
                m_stalls++;
                if (m_stalls >= TMO) begin m_fetching = 0; m_dead = 1; end
            end
        end else begin
            if (pc_load) begin
                if (pc_sel == 2'b00)      m_pc = m_pc + 4;
                else if (pc_sel == 2'b01) m_pc = m_irpc + k * 4;
                else if (pc_sel == 2'b10) m_pc = reg_in - (reg_in % 4);
            end
            if (fetch_en) begin m_fetching = 1; m_stalls = 0; end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        check("mem_req",  {31'b0, mem_bus.mem_req}, {31'b0, m_fetching});
        check("busy",     {31'b0, busy},            {31'b0, m_fetching});
        check("fault",    {31'b0, fault},           {31'b0, m_dead});
        check("ir_valid", {31'b0, ir_valid},        {31'b0, m_valid});
        check("PC",       PC,                       m_pc);
        check("mem_addr", mem_bus.mem_addr,         m_pc);
        check("IR",       IR,                       m_ir);
        check("ir_pc",    ir_pc,                    m_irpc);
    endtask

    task automatic drive(input logic r, input logic fe, input logic pl, input logic [1:0] sel,
                         input logic [31:0] kv, input logic [31:0] rin,
                         input logic rdy, input logic [31:0] rd);
        reset = r; fetch_en = fe; pc_load = pl; pc_sel = sel; k = kv; reg_in = rin;
        mem_bus.mem_ready = rdy; mem_bus.mem_rdata = rd;
    endtask

    typedef struct {
        logic        rst, fen, pld;
        logic [1:0]  sel;
        logic [31:0] kv, rin;
        logic        rdy;
        logic [31:0] rd;
        logic        e_req, e_valid, e_fault;
        logic [31:0] e_pc, e_ir, e_irpc;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic fe, input logic pl, input logic [1:0] sel,
                                input logic [31:0] kv, input logic [31:0] rin,
                                input logic rdy, input logic [31:0] rd,
                                input logic er, input logic ev, input logic ef,
                                input logic [31:0] ep, input logic [31:0] ei, input logic [31:0] eip);
        vec_t v;
        v.rst = r; v.fen = fe; v.pld = pl; v.sel = sel; v.kv = kv; v.rin = rin; v.rdy = rdy; v.rd = rd;
        v.e_req = er; v.e_valid = ev; v.e_fault = ef; v.e_pc = ep; v.e_ir = ei; v.e_irpc = eip;
        return v;
    endfunction

    vec_t tbl[21];

    initial begin
        int ready_pct;

        tbl[0]  = mk(1,0,0,2'b00,0,0,0,0,                        0,0,0,32'h0,        32'h0,        32'h0);
        tbl[1]  = mk(0,1,0,2'b00,0,0,0,0,                        1,0,0,32'h0,        32'h0,        32'h0);
        tbl[2]  = mk(0,0,0,2'b00,0,0,0,0,                        1,0,0,32'h0,        32'h0,        32'h0);
        tbl[3]  = mk(0,0,0,2'b00,0,0,1,32'h9100_0421,            0,1,0,32'h4,        32'h9100_0421,32'h0);
        tbl[4]  = mk(0,0,0,2'b00,0,0,0,0,                        0,0,0,32'h4,        32'h9100_0421,32'h0);
        tbl[5]  = mk(0,1,0,2'b00,0,0,0,0,                        1,0,0,32'h4,        32'h9100_0421,32'h0);
        tbl[6]  = mk(0,0,0,2'b00,0,0,1,32'h1111_2222,            0,1,0,32'h8,        32'h1111_2222,32'h4);
        tbl[7]  = mk(0,1,0,2'b00,0,0,0,0,                        1,0,0,32'h8,        32'h1111_2222,32'h4);
        tbl[8]  = mk(0,0,0,2'b00,0,0,1,32'h3333_4444,            0,1,0,32'hC,        32'h3333_4444,32'h8);
        tbl[9]  = mk(0,0,1,2'b01,32'hFFFF_FFFE,0,0,0,            0,0,0,32'h0,        32'h3333_4444,32'h8);
        tbl[10] = mk(0,1,1,2'b10,0,32'h0000_0103,0,0,            1,0,0,32'h100,      32'h3333_4444,32'h8);
        tbl[11] = mk(0,1,1,2'b10,0,32'h0000_0200,0,0,            1,0,0,32'h100,      32'h3333_4444,32'h8);
        tbl[12] = mk(0,0,0,2'b00,0,0,1,32'h5555_6666,            0,1,0,32'h104,      32'h5555_6666,32'h100);
        tbl[13] = mk(0,0,1,2'b10,0,32'hFFFF_FFFF,0,0,            0,0,0,32'hFFFF_FFFC,32'h5555_6666,32'h100);
        tbl[14] = mk(0,1,0,2'b00,0,0,0,0,                        1,0,0,32'hFFFF_FFFC,32'h5555_6666,32'h100);
        tbl[15] = mk(0,0,0,2'b00,0,0,1,32'h7777_8888,            0,1,0,32'h0,        32'h7777_8888,32'hFFFF_FFFC);
        tbl[16] = mk(0,0,1,2'b00,0,0,0,0,                        0,0,0,32'h4,        32'h7777_8888,32'hFFFF_FFFC);
        tbl[17] = mk(0,0,1,2'b11,0,0,1,32'hDEAD_BEEF,            0,0,0,32'h4,        32'h7777_8888,32'hFFFF_FFFC);
        tbl[18] = mk(0,1,0,2'b00,0,0,0,0,                        1,0,0,32'h4,        32'h7777_8888,32'hFFFF_FFFC);
        tbl[19] = mk(0,0,0,2'b00,0,0,0,0,                        1,0,0,32'h4,        32'h7777_8888,32'hFFFF_FFFC);
        tbl[20] = mk(1,0,0,2'b00,0,0,0,0,                        0,0,0,32'h0,        32'h0,        32'h0);

        drive(1, 0, 0, 2'b00, 0, 0, 0, 0);
        @(negedge clock);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].fen, tbl[i].pld, tbl[i].sel, tbl[i].kv, tbl[i].rin,
                  tbl[i].rdy, tbl[i].rd);
            step();
            check($sformatf("tbl%0d_req", i),   {31'b0, mem_bus.mem_req}, {31'b0, tbl[i].e_req});
            check($sformatf("tbl%0d_valid", i), {31'b0, ir_valid},        {31'b0, tbl[i].e_valid});
            check($sformatf("tbl%0d_fault", i), {31'b0, fault},           {31'b0, tbl[i].e_fault});
            check($sformatf("tbl%0d_pc", i),    PC,                       tbl[i].e_pc);
            check($sformatf("tbl%0d_addr", i),  mem_bus.mem_addr,         tbl[i].e_pc);
            check($sformatf("tbl%0d_ir", i),    IR,                       tbl[i].e_ir);
            check($sformatf("tbl%0d_irpc", i),  ir_pc,                    tbl[i].e_irpc);
        end

        // Timeout: TMO stalled WAIT cycles end in a sticky fault.
        drive(0, 1, 0, 2'b00, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
        for (int i = 1; i < TMO; i++) begin
            step();
            check($sformatf("tmo_wait%0d_req", i), {31'b0, mem_bus.mem_req}, 32'd1);
            check($sformatf("tmo_wait%0d_fault", i), {31'b0, fault}, 32'd0);
        end
        step();
        check("tmo_fault", {31'b0, fault}, 32'd1);
        check("tmo_req_low", {31'b0, mem_bus.mem_req}, 32'd0);
        drive(0, 1, 1, 2'b10, 0, 32'h0000_0040, 1, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("tmo_sticky%0d_fault", i), {31'b0, fault}, 32'd1);
            check($sformatf("tmo_sticky%0d_req", i), {31'b0, mem_bus.mem_req}, 32'd0);
            check($sformatf("tmo_sticky%0d_pc", i), PC, 32'h0);
        end
        drive(1, 0, 0, 2'b00, 0, 0, 0, 0);
        step();
        check("tmo_reset_fault", {31'b0, fault}, 32'd0);
        check("tmo_reset_pc", PC, RST_PC);

        // Randomized traffic; stall probability varies so timeouts also occur.
        ready_pct = 4;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) ready_pct = (c % 192 == 128) ? 0 : int'($urandom_range(1, 9));
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 9) < 3), 2'($urandom_range(0, 3)),
                  $urandom, $urandom, (int'($urandom_range(0, 9)) < ready_pct), $urandom);
            if (c % 500 == 0) reset = 1'b1;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
